spi_flash_reader: RTL and testbench

SPI master that fetches the Atom ROM image from the board's configuration SPI flash and streams it, one byte at a time, into the boot loader's RAM write sequencer. It replaces the external host as the source of the image: on `start` it issues a flash READ command at a fixed flash offset and clocks out exactly `BYTE_COUNT` bytes through a valid/ready byte port. It sits directly upstream of the bootstrap RAM writer.

---
 rtl/spi_flash_reader_pkg.sv | 16 +
 rtl/spi_sck_divider.sv | 41 ++++
 rtl/spi_flash_reader.sv | 154 +++++++++++++++
 tb/tb_spi_flash_reader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_reader_pkg.sv
// spi_flash_reader_pkg: flash opcodes, image defaults and reader FSM state encoding.
package spi_flash_reader_pkg;
    localparam logic [7:0]  OP_READ              = 8'h03;
    localparam logic [7:0]  OP_FAST_READ         = 8'h0B;
    localparam logic [23:0] DEF_FLASH_START_ADDR = 24'h0B0000;
    localparam logic [23:0] DEF_BYTE_COUNT       = 24'h0D700;
    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_FLUSH,
        S_DONE
    } state_t;
endpackage

// File: rtl/spi_sck_divider.sv
// spi_sck_divider: mode-0 SCK generator with CLK_DIV-cycle half periods, edge strobes
// and a hold input that parks SCK low at the end of its low phase.
module spi_sck_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_b,
    input  logic en,
    input  logic hold,
    output logic sck,
    output logic rise,
    output logic fall,
    output logic low_done
);
    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sck_q, sck_d;
    logic          last;

    always_comb begin
        last     = cnt_q == CW'(CLK_DIV - 1);
        low_done = en && !sck_q && last;
        rise     = low_done && !hold;
        fall     = en && sck_q && last;
        sck_d    = en && (rise || (sck_q && !fall));
        cnt_d    = (!en || rise || fall) ? '0 : last ? cnt_q : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;
endmodule

// File: rtl/spi_flash_reader.sv
// spi_flash_reader: streams BYTE_COUNT bytes from SPI flash into a valid/ready byte port.
// Define FLASH_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks instead of READ (0x03).
module spi_flash_reader
    import spi_flash_reader_pkg::*;
#(
    parameter logic [23:0] FLASH_START_ADDR = DEF_FLASH_START_ADDR,
    parameter logic [23:0] BYTE_COUNT       = DEF_BYTE_COUNT,
    parameter int          CLK_DIV          = 4
) (
    input  logic       clk,
    input  logic       reset_b,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       flash_SCK,
    output logic       flash_SSEL,
    output logic       flash_MOSI,
    input  logic       flash_MISO,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    input  logic       byte_ready
);
`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] OPCODE   = OP_FAST_READ;
    localparam state_t     HDR_NEXT = S_DUMMY;
`else
    localparam logic [7:0] OPCODE   = OP_READ;
    localparam state_t     HDR_NEXT = S_DATA;
`endif

    state_t      state_q, state_d;
    logic [4:0]  bit_q, bit_d;
    logic [23:0] rem_q, rem_d;
    logic [31:0] tx_q, tx_d;
    logic [6:0]  rx_q, rx_d;
    logic [7:0]  data_q, data_d;
    logic        mosi_q, mosi_d, ssel_q, ssel_d, busy_q, busy_d;
    logic        done_q, done_d, valid_q, valid_d;
    logic        sck_en, sck_hold, sck_rise, sck_fall, sck_low_done, load;

    assign sck_en   = state_q inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};
    // Park SCK before the 8th edge while the holding byte is unconsumed, and after the last byte.
    assign sck_hold = (state_q == S_DATA) &&
                      (rem_q == '0 || (bit_q == 5'd7 && valid_q && !byte_ready));

    spi_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .reset_b  (reset_b),
        .en       (sck_en),
        .hold     (sck_hold),
        .sck      (flash_SCK),
        .rise     (sck_rise),
        .fall     (sck_fall),
        .low_done (sck_low_done)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        rem_d   = rem_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        mosi_d  = mosi_q;
        ssel_d  = ssel_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = (state_q == S_DATA) && sck_rise && (bit_q == 5'd7);
        valid_d = load || (valid_q && !byte_ready);
        data_d  = load ? {rx_q, flash_MISO} : data_q;
        if (sck_fall) begin
            tx_d   = {tx_q[30:0], 1'b0};
            mosi_d = tx_q[30];
        end
        if (sck_rise) rx_d = {rx_q[5:0], flash_MISO};
        case (state_q)
            S_IDLE: if (start) begin
                busy_d = 1'b1;
                if (BYTE_COUNT == '0) state_d = S_DONE;
                else begin
                    state_d = S_CMD;
                    ssel_d  = 1'b0;
                    tx_d    = {OPCODE, FLASH_START_ADDR};
                    mosi_d  = OPCODE[7];
                    rem_d   = BYTE_COUNT;
                    bit_d   = '0;
                end
            end
            S_CMD: if (sck_rise) begin
                bit_d   = (bit_q == 5'd7) ? '0 : bit_q + 5'd1;
                state_d = (bit_q == 5'd7) ? S_ADDR : S_CMD;
            end
            S_ADDR: if (sck_rise) begin
                bit_d   = (bit_q == 5'd23) ? '0 : bit_q + 5'd1;
                state_d = (bit_q == 5'd23) ? HDR_NEXT : S_ADDR;
            end
`ifdef FLASH_FAST_READ_EN
            S_DUMMY: if (sck_rise) begin
                bit_d   = (bit_q == 5'd7) ? '0 : bit_q + 5'd1;
                state_d = (bit_q == 5'd7) ? S_DATA : S_DUMMY;
            end
`endif
            S_DATA: begin
                if (sck_rise) bit_d = (bit_q == 5'd7) ? '0 : bit_q + 5'd1;
                if (load) rem_d = rem_q - 24'd1;
                if (rem_q == '0 && sck_low_done) begin
                    ssel_d  = 1'b1;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: if (!valid_q || byte_ready) state_d = S_DONE;
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= S_IDLE;
            bit_q   <= '0;
            rem_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            mosi_q  <= 1'b0;
            ssel_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            rem_q   <= rem_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            data_q  <= data_d;
            mosi_q  <= mosi_d;
            ssel_q  <= ssel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign flash_SSEL = ssel_q;
    assign flash_MOSI = mosi_q;
    assign byte_valid = valid_q;
    assign byte_data  = data_q;
endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader: randomized streaming against a behavioural SPI flash and byte consumer.
module tb_spi_flash_reader;
    localparam int          DIV  = 4;
    localparam int          N    = 12;
    localparam logic [23:0] BASE = 24'h0B0000;
`ifdef FLASH_FAST_READ_EN
    localparam int          HDR  = 40;
    localparam logic [7:0]  OPC  = 8'h0B;
`else
    localparam int          HDR  = 32;
    localparam logic [7:0]  OPC  = 8'h03;
`endif

    logic       clk = 0, reset_b = 1, start = 0, byte_ready = 1, flash_MISO = 0;
    logic       busy, done, flash_SCK, flash_SSEL, flash_MOSI, byte_valid;
    logic [7:0] byte_data;
    logic       start0 = 0, ready0 = 1, miso0 = 0;
    logic       busy0, done0, sck0, ssel0, mosi0, valid0;
    logic [7:0] data0;
    logic [7:0] mem [64];
    logic [63:0] sr;
    int n_checks = 0, n_fail = 0;
    int cyc = 0, rises = 0, stray = 0, nssel = 0, t_ssel = 0, t_rise = 0, ssel0_falls = 0;

    spi_flash_reader #(.FLASH_START_ADDR(BASE), .BYTE_COUNT(24'(N)), .CLK_DIV(DIV)) dut (
        .clk(clk), .reset_b(reset_b), .start(start), .busy(busy), .done(done),
        .flash_SCK(flash_SCK), .flash_SSEL(flash_SSEL), .flash_MOSI(flash_MOSI),
        .flash_MISO(flash_MISO), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready)
    );

    spi_flash_reader #(.FLASH_START_ADDR(BASE), .BYTE_COUNT(24'd0), .CLK_DIV(2)) dut0 (
        .clk(clk), .reset_b(reset_b), .start(start0), .busy(busy0), .done(done0),
        .flash_SCK(sck0), .flash_SSEL(ssel0), .flash_MOSI(mosi0),
        .flash_MISO(miso0), .byte_valid(valid0), .byte_data(data0),
        .byte_ready(ready0)
    );

    always #5 clk = ~clk;
    always @(negedge clk) cyc++;
    always @(negedge ssel0) ssel0_falls++;

    function automatic logic [7:0] mem_at(input logic [23:0] a);
        logic [23:0] off;
        off = a - BASE;
        return (off < 24'd64) ? mem[off[5:0]] : 8'h00;
    endfunction

    // Flash: latches header bits on SCK rise, drives read data MSB first on SCK fall.
    always @(posedge flash_SCK or negedge flash_SSEL) begin
        if (!flash_SCK) begin
            rises = 0;
            sr = '0;
            nssel++;
            t_ssel = cyc;
        end else if (flash_SSEL) stray++;
        else begin
            if (rises < HDR) sr = {sr[62:0], flash_MOSI};
            if (rises == 0) t_rise = cyc;
            rises++;
        end
    end

    always @(negedge flash_SCK) begin
        int k;
        logic [7:0] b;
        if (!flash_SSEL && rises >= HDR) begin
            k = rises - HDR;
            b = mem_at(sr[HDR-9 -: 24] + 24'(k / 8));
            flash_MISO = b[7 - k % 8];
        end
    end

    task automatic test_reset();
        #1 reset_b = 0;
        #20;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (flash_SCK !== 1'b0) begin n_fail++; $display("FAIL reset_sck: got %b want 0", flash_SCK); end
        n_checks++; if (flash_SSEL !== 1'b1) begin n_fail++; $display("FAIL reset_ssel: got %b want 1", flash_SSEL); end
        n_checks++; if (flash_MOSI !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", flash_MOSI); end
        n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", byte_valid); end
        n_checks++; if (byte_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", byte_data); end
        @(negedge clk) reset_b = 1;
    endtask

    task automatic test_stream(input int stall, input bit rnd, input bit poke, input string name);
        logic [7:0] q[$];
        int tacc[$];
        int ndone = 0, left = 0, done_at = 0, park_rises = -1, s0, n0;
        logic park_sck = 1'bx;
        bit seen = 0, fin = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        if (name == "basic") begin
            mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h00; mem[3] = 8'hFF;
        end
        s0 = stray;
        n0 = nssel;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start: got %b want 1", name, busy); end
        for (int c = 0; c < 20000 && !fin; c++) begin
            @(negedge clk);
            start = poke && (c == 100);
            if (!seen && byte_valid) begin
                seen = 1;
                left = stall;
            end
            if (left > 0) begin
                byte_ready = 0;
                left--;
                if (left == 0) begin
                    park_rises = rises;
                    park_sck = flash_SCK;
                end
            end else byte_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (byte_valid && byte_ready) begin
                q.push_back(byte_data);
                tacc.push_back(c);
            end
            if (done) begin
                ndone++;
                done_at = c;
            end
            if (ndone > 0 && c >= done_at + 4) fin = 1;
        end
        start = 0;
        byte_ready = 1;
        n_checks++; if (!fin) begin n_fail++; $display("FAIL %s timeout: done seen %0d times, want 1 before budget", name, ndone); end
        n_checks++; if (q.size() != N) begin n_fail++; $display("FAIL %s byte_count: got %0d want %0d", name, q.size(), N); end
        for (int i = 0; i < N; i++) begin
            logic [7:0] g;
            g = (i < q.size()) ? q[i] : 8'hxx;
            n_checks++; if (g !== mem[i]) begin n_fail++; $display("FAIL %s byte[%0d]: got %h want %h", name, i, g, mem[i]); end
        end
        n_checks++; if (ndone != 1) begin n_fail++; $display("FAIL %s done_pulses: got %0d want 1", name, ndone); end
        n_checks++; if (flash_SSEL !== 1'b1) begin n_fail++; $display("FAIL %s ssel_after: got %b want 1", name, flash_SSEL); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy_after: got %b want 0", name, busy); end
        n_checks++; if (sr[HDR-1 -: 8] !== OPC) begin n_fail++; $display("FAIL %s opcode: got %h want %h", name, sr[HDR-1 -: 8], OPC); end
        n_checks++; if (sr[HDR-9 -: 24] !== BASE) begin n_fail++; $display("FAIL %s address: got %h want %h", name, sr[HDR-9 -: 24], BASE); end
`ifdef FLASH_FAST_READ_EN
        n_checks++; if (sr[7:0] !== 8'h00) begin n_fail++; $display("FAIL %s dummy: got %h want 00", name, sr[7:0]); end
`endif
        n_checks++; if (rises != HDR + 8 * N) begin n_fail++; $display("FAIL %s sck_rises: got %0d want %0d", name, rises, HDR + 8 * N); end
        n_checks++; if (stray != s0) begin n_fail++; $display("FAIL %s sck_without_ssel: got %0d want 0", name, stray - s0); end
        n_checks++; if (nssel != n0 + 1) begin n_fail++; $display("FAIL %s ssel_assertions: got %0d want 1", name, nssel - n0); end
        n_checks++; if (t_rise - t_ssel < DIV) begin n_fail++; $display("FAIL %s ssel_setup: got %0d want >=%0d", name, t_rise - t_ssel, DIV); end
        if (stall > 0) begin
            n_checks++; if (park_sck !== 1'b0) begin n_fail++; $display("FAIL %s parked_sck: got %b want 0", name, park_sck); end
            n_checks++; if (park_rises != HDR + 15) begin n_fail++; $display("FAIL %s parked_rises: got %0d want %0d", name, park_rises, HDR + 15); end
        end
        if (!rnd && stall == 0 && tacc.size() > 1) begin
            n_checks++; if (tacc[1] - tacc[0] != 16 * DIV) begin n_fail++; $display("FAIL %s byte_interval: got %0d want %0d", name, tacc[1] - tacc[0], 16 * DIV); end
        end
    endtask

    task automatic test_zero_count();
        int f0;
        f0 = ssel0_falls;
        @(negedge clk) start0 = 1;
        @(negedge clk) start0 = 0;
        n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL zero busy_c1: got %b want 1", busy0); end
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL zero done_c1: got %b want 0", done0); end
        @(negedge clk);
        n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL zero done_c2: got %b want 1", done0); end
        n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL zero busy_c2: got %b want 0", busy0); end
        @(negedge clk);
        n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL zero done_c3: got %b want 0", done0); end
        n_checks++; if (ssel0_falls != f0 || ssel0 !== 1'b1) begin n_fail++; $display("FAIL zero ssel: falls %0d level %b want 0 falls level 1", ssel0_falls - f0, ssel0); end
    endtask

    task automatic test_reset_mid();
        bit ok = 0;
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (rises >= 12 && flash_SCK) begin
                ok = 1;
                break;
            end
        end
        n_checks++; if (!ok) begin n_fail++; $display("FAIL midreset reach_addr: got %0d rises want >=12 with SCK high", rises); end
        #2 reset_b = 0;
        #1;
        n_checks++; if (flash_SSEL !== 1'b1) begin n_fail++; $display("FAIL midreset ssel: got %b want 1", flash_SSEL); end
        n_checks++; if (flash_SCK !== 1'b0) begin n_fail++; $display("FAIL midreset sck: got %b want 0", flash_SCK); end
        n_checks++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL midreset valid: got %b want 0", byte_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset busy: got %b want 0", busy); end
        @(negedge clk) reset_b = 1;
        test_stream(0, 0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_stream(0, 0, 0, "basic");
        test_stream(500, 0, 0, "stall");
        test_stream(0, 1, 0, "random_ready");
        test_stream(0, 0, 1, "start_busy");
        test_zero_count();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
